// File: rtl/fare_meter.sv
// Taximeter trip FSM with distance-based fare accumulation and a serial binary-to-BCD converter.
// Optional build macro FARE_NIGHT_SURCHARGE_EN adds a night input that raises base fare and step by one fifth.
module fare_meter #(
    parameter int BASE_FARE_NORMAL  = 3800,
    parameter int BASE_FARE_PREMIUM = 6500,
    parameter int STEP_NORMAL       = 100,
    parameter int STEP_PREMIUM      = 200,
    parameter int BASE_DIST         = 16,
    parameter int STEP_DIST         = 8,
    parameter int FARE_MAX          = 99999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        normal,
    input  logic        premium,
    input  logic        stop,
    input  logic        clear,
    input  logic        dist_tick,
`ifdef FARE_NIGHT_SURCHARGE_EN
    input  logic        night,
`endif
    output logic        status,
    output logic        mode_premium,
    output logic [1:0]  trip_state,
    output logic [16:0] fare,
    output logic [19:0] fare_bcd,
    output logic        bcd_valid
);
    localparam int BW = $clog2(BASE_DIST + 1);
    localparam int SW = $clog2(STEP_DIST + 1);
    localparam logic [BW-1:0] C_BASE_DIST = BW'(BASE_DIST);
    localparam logic [SW-1:0] C_STEP_LAST = SW'(STEP_DIST - 1);
    localparam logic [17:0]   C_BN  = 18'(BASE_FARE_NORMAL);
    localparam logic [17:0]   C_BP  = 18'(BASE_FARE_PREMIUM);
    localparam logic [17:0]   C_SN  = 18'(STEP_NORMAL);
    localparam logic [17:0]   C_SP  = 18'(STEP_PREMIUM);
    localparam logic [17:0]   C_MAX = 18'(FARE_MAX);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVING = 2'd1,
        S_PAY     = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_status;
    logic            r_mode;
    logic            r_night;
    logic [16:0]     r_fare;
    logic [BW-1:0]   r_base_cnt;
    logic [SW-1:0]   r_step_cnt;

    logic            w_night_start;
    logic [17:0]     w_base_n;
    logic [17:0]     w_base_p;
    logic [17:0]     w_start_raw;
    logic [16:0]     w_start_fare;
    logic [17:0]     w_step;
    logic [17:0]     w_sum;
    logic [16:0]     w_fare_inc;

    function automatic logic [17:0] surcharge(input logic [17:0] x);
        return x + x / 18'd5;
    endfunction

`ifdef FARE_NIGHT_SURCHARGE_EN
    assign w_night_start = night;
`else
    assign w_night_start = 1'b0;
`endif

    assign w_base_n     = w_night_start ? surcharge(C_BN) : C_BN;
    assign w_base_p     = w_night_start ? surcharge(C_BP) : C_BP;
    assign w_start_raw  = premium ? w_base_p : w_base_n;
    assign w_start_fare = (w_start_raw > C_MAX) ? C_MAX[16:0] : w_start_raw[16:0];

    // Sum is 18 bits wide so the ceiling compare never sees a wrapped value.
    assign w_step     = r_mode ? (r_night ? surcharge(C_SP) : C_SP)
                               : (r_night ? surcharge(C_SN) : C_SN);
    assign w_sum      = {1'b0, r_fare} + w_step;
    assign w_fare_inc = (w_sum > C_MAX) ? C_MAX[16:0] : w_sum[16:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_status   <= 1'b0;
            r_mode     <= 1'b0;
            r_night    <= 1'b0;
            r_fare     <= '0;
            r_base_cnt <= '0;
            r_step_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (premium || normal) begin
                        r_state    <= S_DRIVING;
                        r_status   <= 1'b1;
                        r_mode     <= premium;
                        r_night    <= w_night_start;
                        r_fare     <= w_start_fare;
                        r_base_cnt <= '0;
                        r_step_cnt <= '0;
                    end
                end
                S_DRIVING: begin
                    if (dist_tick) begin
                        if (r_base_cnt != C_BASE_DIST) begin
                            r_base_cnt <= r_base_cnt + 1'b1;
                        end else if (r_step_cnt == C_STEP_LAST) begin
                            r_step_cnt <= '0;
                            r_fare     <= w_fare_inc;
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                    if (stop) begin
                        r_state <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (clear) begin
                        r_state    <= S_IDLE;
                        r_status   <= 1'b0;
                        r_mode     <= 1'b0;
                        r_night    <= 1'b0;
                        r_fare     <= '0;
                        r_base_cnt <= '0;
                        r_step_cnt <= '0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_status <= 1'b0;
                end
            endcase
        end
    end

    // Double dabble: one shift per cycle, digits >= 5 get +3 before each shift.
    logic        r_bcd_busy;
    logic [4:0]  r_bcd_cnt;
    logic [16:0] r_shift;
    logic [19:0] r_acc;
    logic [16:0] r_last;
    logic [19:0] r_fare_bcd;
    logic        r_bcd_valid;
    logic [19:0] w_acc_adj;
    logic [19:0] w_acc_next;

    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < 5; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_acc_next = {w_acc_adj[18:0], r_shift[16]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd_busy  <= 1'b0;
            r_bcd_cnt   <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_last      <= '0;
            r_fare_bcd  <= '0;
            r_bcd_valid <= 1'b1;
        end else if (r_bcd_busy) begin
            r_acc   <= w_acc_next;
            r_shift <= {r_shift[15:0], 1'b0};
            if (r_bcd_cnt == 5'd16) begin
                r_bcd_busy  <= 1'b0;
                r_fare_bcd  <= w_acc_next;
                // A fare change during conversion leaves valid low until the follow-up pass.
                r_bcd_valid <= (r_fare == r_last);
            end else begin
                r_bcd_cnt <= r_bcd_cnt + 1'b1;
            end
        end else if (r_fare != r_last) begin
            r_bcd_busy  <= 1'b1;
            r_bcd_cnt   <= '0;
            r_shift     <= r_fare;
            r_last      <= r_fare;
            r_acc       <= '0;
            r_bcd_valid <= 1'b0;
        end
    end

    assign status       = r_status;
    assign mode_premium = r_mode;
    assign trip_state   = r_state;
    assign fare         = r_fare;
    assign fare_bcd     = r_fare_bcd;
    assign bcd_valid    = r_bcd_valid;
endmodule

// File: doc/fare_meter.md
# fare_meter

Trip-state and fare-accumulation engine for the taximeter. It sits directly upstream of the LCD text driver and supplies the `status` flag that selects the EMPTY or DRIVING screen. It also supplies the running fare as binary and as 5-digit packed BCD, ready for character rendering. The block consumes start/stop/clear button pulses and a distance tick, and applies a base fare plus per-distance increments for normal or premium service.

## Interface
- `BASE_FARE_NORMAL`, default 3800: fare loaded on a normal start.
- `BASE_FARE_PREMIUM`, default 6500: fare loaded on a premium start.
- `STEP_NORMAL`, default 100: fare increment per step, normal mode.
- `STEP_PREMIUM`, default 200: fare increment per step, premium mode.
- `BASE_DIST`, default 16: number of `dist_tick`s covered by the base fare (≥1).
- `STEP_DIST`, default 8: number of `dist_tick`s per increment after the base distance (≥1).
- `FARE_MAX`, default 99999: saturation ceiling (≤99999).
- `clk  in  1`: clock.
- `reset  in  1`: asynchronous, active-high.
- `normal  in  1`: one-cycle pulse; starts a normal trip.
- `premium  in  1`: one-cycle pulse; starts a premium trip.
- `stop  in  1`: one-cycle pulse; ends the trip.
- `clear  in  1`: one-cycle pulse; returns the meter to empty after payment.
- `dist_tick  in  1`: one-cycle pulse per distance unit.
- `status  out  1`: 1 in DRIVING or PAY; feeds the LCD driver.
- `mode_premium  out  1`: trip mode, latched at start.
- `trip_state  out  2`: 0 = IDLE, 1 = DRIVING, 2 = PAY.
- `fare  out  17`: binary fare.
- `fare_bcd  out  20`: 5 packed BCD digits of `fare`, MSD in [19:16].
- `bcd_valid  out  1`: `fare_bcd` matches `fare`.

## Operation
- **Reset values:** trip_state = IDLE, fare = 0, fare_bcd = 0, bcd_valid = 1, status = 0, mode_premium = 0. All internal counters are cleared.
- **IDLE:**
  - `premium` → DRIVING, mode_premium = 1, fare = BASE_FARE_PREMIUM.
  - Else `normal` → DRIVING, mode_premium = 0, fare = BASE_FARE_NORMAL.
  - Premium wins when both are asserted in the same cycle.
  - `stop`, `clear` and `dist_tick` are ignored.
- **DRIVING:**
  - Each `dist_tick` advances the distance logic.
  - The first BASE_DIST ticks add nothing.
  - After that, every STEP_DIST-th tick adds the mode's step: fare = min(fare + step, FARE_MAX).
  - `normal` and `premium` are ignored.
  - `stop` → PAY. A `dist_tick` in the same cycle as `stop` is still counted.
- **PAY:**
  - fare is frozen; `dist_tick`, `normal`, `premium` and `stop` are ignored.
  - `clear` → IDLE with fare = 0, distance counters cleared and mode_premium = 0.
- **Distance counters:**
  - base_cnt saturates at BASE_DIST.
  - step_cnt counts 0..STEP_DIST-1 and wraps to 0 on the increment tick.
  - Both counters clear on trip start.
- **Arithmetic:** the sum is computed 18 bits wide before the saturation compare, so there is no wrap-around.
- **BCD converter:** sequential shift-add-3 (double dabble), 17 iterations, one bit per cycle.
  - A conversion starts whenever `fare` differs from the last converted value and the converter is idle.
  - The operand is latched at start.
  - `fare_bcd` holds its previous value until completion.
  - If `fare` changed during a conversion, a new conversion starts on the cycle after completion.

## Timing
- **Start:** the start pulse is sampled at edge N; trip_state, status, mode_premium and fare update at edge N.
- **Fare increment:** registered on the same edge that samples the qualifying `dist_tick`.
- **BCD latency:**
  - fare changes at edge N.
  - The converter loads at N+1, and bcd_valid = 0 from N+1.
  - It shifts on edges N+2..N+18.
  - fare_bcd updates and bcd_valid = 1 at edge N+18.
- **Worst case:** with a change during conversion, valid is reached 18 cycles after the end of the current conversion.
- **Reset mid-conversion:** the conversion aborts immediately and all outputs return to their reset values.

## Configuration
- Macro: `FARE_NIGHT_SURCHARGE_EN`.
- **Defined:**
  - Adds input `night  in  1`, sampled on the trip-start cycle and latched for the whole trip.
  - When the latch is set, the base fare and step are each x + x/5, using integer division: normal 4560/120, premium 7800/240.
  - Saturation still applies.
- **Undefined:** no `night` port; the base fares and steps from the parameters are used unchanged.

## Test plan
All cases use default parameters.
1. **Normal start:** reset, then `normal` → next cycle status = 1, fare = 3800, trip_state = 1; 18 cycles later fare_bcd = 20'h03800, bcd_valid = 1.
2. **Normal distance pricing:** normal start, then 16 ticks → fare 3800; tick 24 → 3900; tick 48 → 4200.
3. **Simultaneous start:** `normal` and `premium` in the same cycle → mode_premium = 1, fare = 6500; 24 ticks → 6700.
4. **Saturation:** with FARE_MAX = 4000, normal start, then 16 + 8×3 ticks → fare 4000, and further ticks keep it at 4000.
5. **Stop and clear:**
   - `stop` together with the 24th tick (normal mode) → PAY, fare 3900.
   - 10 more ticks → still 3900.
   - `clear` → IDLE, fare = 0, status = 0, and 18 cycles later fare_bcd = 0.
6. **Reset mid-conversion:** reset asserted 5 cycles after a fare change → outputs immediately 0, bcd_valid = 1, trip_state = IDLE.
